// File: rtl/blink_scheduler.sv
// Multi-channel LED blink scheduler: per-channel interval counters, valid/ready config port and LFSR random intervals.
// Optional phase realignment input sync_start is compiled in when BLINK_PHASE_SYNC_EN is defined.
module blink_scheduler #(
    parameter int          NUM_CH    = 3,
    parameter int          CNT_W     = 8,
    parameter int          PULSE_W   = 1,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rstbtn_n,
    input  logic              en,
`ifdef BLINK_PHASE_SYNC_EN
    input  logic              sync_start,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_chan,
    input  logic [CNT_W-1:0]  cfg_interval,
    input  logic              cfg_rand,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] leds
);

    localparam logic [15:0]      LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
    localparam logic [3:0]       PT_LOAD   = 4'(PULSE_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0]  ivl_q    [NUM_CH];
    logic [CNT_W-1:0]  ivl_d    [NUM_CH];
    logic [CNT_W-1:0]  sh_ivl_q [NUM_CH];
    logic [CNT_W-1:0]  sh_ivl_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q    [NUM_CH];
    logic [CNT_W-1:0]  cnt_d    [NUM_CH];
    logic [3:0]        pt_q     [NUM_CH];
    logic [3:0]        pt_d     [NUM_CH];
    logic [NUM_CH-1:0] rnd_q, rnd_d;
    logic [NUM_CH-1:0] sh_rnd_q, sh_rnd_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [15:0]       lfsr_q, lfsr_d;
    logic              err_q, err_d;

    logic [CNT_W-1:0]  rnd_ivl;
    logic              accept;
    logic              in_range;

    always_comb begin
        // NOTE: every signal written here gets its hold value first, so no path can leave one unassigned and infer a latch.
        ivl_d     = ivl_q;
        sh_ivl_d  = sh_ivl_q;
        cnt_d     = cnt_q;
        pt_d      = pt_q;
        rnd_d     = rnd_q;
        sh_rnd_d  = sh_rnd_q;
        pend_d    = pend_q;
        lfsr_d    = lfsr_q;
        err_d     = err_q;
        cfg_ready = 1'b1;
        in_range  = 1'b0;

        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_chan == 2'(i)) begin
                in_range  = 1'b1;
                cfg_ready = !pend_q[i];
            end
        end
        accept  = cfg_valid && cfg_ready;
        rnd_ivl = (lfsr_q[CNT_W-1:0] == '0) ? CNT_ONE : lfsr_q[CNT_W-1:0];

        if (en) begin
            lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
        if (accept && !in_range) begin
            err_d = 1'b1;
        end

        for (int i = 0; i < NUM_CH; i++) begin
            if (en && pt_q[i] != 4'd0) begin
                pt_d[i] = pt_q[i] - 4'd1;
            end

            if (ivl_q[i] == '0) begin
                // A disabled channel never wraps, so its pending update lands right away.
                if (pend_q[i]) begin
                    ivl_d[i]  = sh_ivl_q[i];
                    rnd_d[i]  = sh_rnd_q[i];
                    pend_d[i] = 1'b0;
                    cnt_d[i]  = '0;
                end
            end else if (en) begin
                if (cnt_q[i] == ivl_q[i]) begin
                    cnt_d[i] = '0;
                    pt_d[i]  = PT_LOAD;
                    if (pend_q[i]) begin
                        ivl_d[i]  = sh_ivl_q[i];
                        rnd_d[i]  = sh_rnd_q[i];
                        pend_d[i] = 1'b0;
                    end else if (rnd_q[i]) begin
                        ivl_d[i] = rnd_ivl;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end

`ifdef BLINK_PHASE_SYNC_EN
            if (sync_start) begin
                cnt_d[i] = '0;
                pt_d[i]  = 4'd0;
                if (pend_q[i]) begin
                    ivl_d[i]  = sh_ivl_q[i];
                    rnd_d[i]  = sh_rnd_q[i];
                    pend_d[i] = 1'b0;
                end
            end
`endif

            // Accept only happens with pend_q clear, so this never collides with an apply above.
            if (accept && cfg_chan == 2'(i)) begin
                sh_ivl_d[i] = cfg_interval;
                sh_rnd_d[i] = cfg_rand;
                pend_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments; the per-channel arrays are reset explicitly because a reset must clear every interval and pending update.
        if (!rstbtn_n) begin
            lfsr_q   <= LFSR_SEED;
            err_q    <= 1'b0;
            rnd_q    <= '0;
            sh_rnd_q <= '0;
            pend_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                ivl_q[i]    <= '0;
                sh_ivl_q[i] <= '0;
                cnt_q[i]    <= '0;
                pt_q[i]     <= 4'd0;
            end
        end else begin
            lfsr_q   <= lfsr_d;
            err_q    <= err_d;
            rnd_q    <= rnd_d;
            sh_rnd_q <= sh_rnd_d;
            pend_q   <= pend_d;
            ivl_q    <= ivl_d;
            sh_ivl_q <= sh_ivl_d;
            cnt_q    <= cnt_d;
            pt_q     <= pt_d;
        end
    end

    always_comb begin
        leds = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            leds[i] = en && (pt_q[i] != 4'd0);
        end
    end

    assign cfg_err = err_q;

endmodule

// File: tb/tb_blink_scheduler.sv
// Bench for blink_scheduler: two instances (PULSE_W 1 and 3) share stimulus and are checked every cycle
// against a countdown-based reference model of the blink/config rules.
module tb_blink_scheduler;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 8;

    logic              clk = 1'b0;
    logic              rstbtn_n, en, cfg_valid, cfg_rand;
    logic [1:0]        cfg_chan;
    logic [CNT_W-1:0]  cfg_interval;
    logic              ready_a, ready_b, err_a, err_b;
    logic [NUM_CH-1:0] leds_a, leds_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    blink_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PULSE_W(1), .LFSR_SEED(16'hACE1)) dut_a (
        .clk(clk), .rstbtn_n(rstbtn_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(ready_a), .cfg_chan(cfg_chan),
        .cfg_interval(cfg_interval), .cfg_rand(cfg_rand), .cfg_err(err_a), .leds(leds_a)
    );

    blink_scheduler #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PULSE_W(3), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .rstbtn_n(rstbtn_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(ready_b), .cfg_chan(cfg_chan),
        .cfg_interval(cfg_interval), .cfg_rand(cfg_rand), .cfg_err(err_b), .leds(leds_b)
    );

    // Reference model: each channel tracks en-edges remaining until its next wrap instead of a count-up counter.
    int          m_ivl    [4];
    bit          m_rnd    [4];
    int          m_sh_ivl [4];
    bit          m_sh_rnd [4];
    bit          m_pend   [4];
    int          m_rem    [4];
    int          m_pt     [2][4];
    logic [15:0] m_lfsr;
    bit          m_err;
    int          pw       [2] = '{1, 3};

    function automatic bit model_ready(input logic [1:0] c);
        if (int'(c) >= NUM_CH) return 1'b1;
        return !m_pend[c];
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic logic [NUM_CH-1:0] model_leds(input int d);
        logic [NUM_CH-1:0] v;
        v = '0;
        for (int c = 0; c < NUM_CH; c++) v[c] = en && (m_pt[d][c] > 0);
        return v;
    endfunction

    task automatic apply_shadow(input int c);
        m_ivl[c]  = m_sh_ivl[c];
        m_rnd[c]  = m_sh_rnd[c];
        m_pend[c] = 1'b0;
        m_rem[c]  = m_ivl[c] + 1;
    endtask

    always @(posedge clk) begin
        bit acc;
        int lv;
        if (!rstbtn_n) begin
            for (int c = 0; c < 4; c++) begin
                m_ivl[c] = 0; m_rnd[c] = 0; m_sh_ivl[c] = 0; m_sh_rnd[c] = 0;
                m_pend[c] = 0; m_rem[c] = 0; m_pt[0][c] = 0; m_pt[1][c] = 0;
            end
            m_lfsr = 16'hACE1;
            m_err  = 1'b0;
        end else begin
            acc = cfg_valid && model_ready(cfg_chan);
            lv  = (m_lfsr[7:0] == 8'd0) ? 1 : int'(m_lfsr[7:0]);
            for (int c = 0; c < NUM_CH; c++) begin
                for (int d = 0; d < 2; d++)
                    if (en && m_pt[d][c] > 0) m_pt[d][c]--;
                if (m_ivl[c] == 0) begin
                    if (m_pend[c]) apply_shadow(c);
                end else if (en) begin
                    m_rem[c]--;
                    if (m_rem[c] == 0) begin
                        for (int d = 0; d < 2; d++) m_pt[d][c] = pw[d];
                        if (m_pend[c]) apply_shadow(c);
                        else begin
                            if (m_rnd[c]) m_ivl[c] = lv;
                            m_rem[c] = m_ivl[c] + 1;
                        end
                    end
                end
                if (acc && int'(cfg_chan) == c) begin
                    m_sh_ivl[c] = int'(cfg_interval);
                    m_sh_rnd[c] = cfg_rand;
                    m_pend[c]   = 1'b1;
                end
            end
            if (acc && int'(cfg_chan) >= NUM_CH) m_err = 1'b1;
            if (en) m_lfsr = lfsr_next(m_lfsr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // One cycle: drive inputs at the falling edge, then compare outputs against the model.
    task automatic drive(input logic r, input logic e, input logic v, input logic [1:0] ch,
                         input logic [CNT_W-1:0] iv, input logic rd);
        @(negedge clk);
        rstbtn_n = r; en = e; cfg_valid = v; cfg_chan = ch; cfg_interval = iv; cfg_rand = rd;
        #1;
        check("leds_a",  32'(leds_a),  32'(model_leds(0)));
        check("leds_b",  32'(leds_b),  32'(model_leds(1)));
        check("ready_a", 32'(ready_a), 32'(model_ready(cfg_chan)));
        check("ready_b", 32'(ready_b), 32'(model_ready(cfg_chan)));
        check("err_a",   32'(err_a),   32'(m_err));
        check("err_b",   32'(err_b),   32'(m_err));
    endtask

    task automatic idle(input int n, input logic e);
        for (int k = 0; k < n; k++) drive(1'b1, e, 1'b0, 2'd0, '0, 1'b0);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [CNT_W-1:0] iv, input logic rd);
        drive(1'b1, 1'b1, 1'b1, ch, iv, rd);
    endtask

    initial begin
        logic r, e, v, rd;
        logic [1:0] ch;
        logic [CNT_W-1:0] iv;

        rstbtn_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_chan = 2'd0; cfg_interval = '0; cfg_rand = 1'b0;
        repeat (2) @(posedge clk);

        // Basic fixed intervals on ch0 and ch1, ch2 idle.
        wr(2'd0, 8'd9, 1'b0);
        wr(2'd1, 8'd4, 1'b0);
        idle(40, 1'b1);

        // Mid-period interval change on ch1; ready stays low until its next wrap.
        idle(2, 1'b1);
        wr(2'd1, 8'd2, 1'b0);
        for (int k = 0; k < 8; k++) drive(1'b1, 1'b1, 1'b0, 2'd1, '0, 1'b0);
        idle(12, 1'b1);

        // Random mode on ch2.
        wr(2'd2, 8'd3, 1'b1);
        idle(200, 1'b1);

        // Enable gap of 7 cycles mid-count.
        idle(3, 1'b1);
        idle(7, 1'b0);
        idle(30, 1'b1);

        // Out-of-range channel sets the sticky error.
        drive(1'b1, 1'b1, 1'b1, 2'd3, 8'd5, 1'b0);
        for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 1'b0, 2'd3, '0, 1'b0);

        // Short interval with long pulse, then reset mid-pulse with an update pending.
        drive(1'b0, 1'b1, 1'b0, 2'd0, '0, 1'b0);
        wr(2'd0, 8'd1, 1'b0);
        idle(20, 1'b1);
        wr(2'd0, 8'd100, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 2'd0, '0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b0, 2'd0, '0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 2000; n++) begin
            r  = ($urandom_range(0, 299) != 0);
            e  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 3) == 0);
            ch = 2'($urandom_range(0, 3));
            iv = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            rd = ($urandom_range(0, 3) == 0);
            drive(r, e, v, ch, iv, rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blink_scheduler.md
Name: blink_scheduler

Overview:
- Multi-channel LED blink controller: owns per-channel interval counters, loads intervals through a valid/ready config port, and generates the blink pulses.
- Channels run in fixed or pseudo-random interval mode. Random mode uses a 16-bit LFSR, replacing the non-synthesizable $random.
- Sits between the board button/config logic and the LED pins. It is the scheduler for all LED outputs on the chip.

Parameters:
- NUM_CH, 3, number of LED channels (1..4).
- CNT_W, 8, interval/counter width in bits.
- PULSE_W, 1, LED high time in cycles per blink (1..15).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rstbtn_n  input  1  reset; synchronous, active-low.
- en  input  1  global run enable.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  config request can be accepted.
- cfg_chan  input  2  target channel index.
- cfg_interval  input  CNT_W  new interval; 0 disables the channel.
- cfg_rand  input  1  1 = random-interval mode for the target channel.
- cfg_err  output  1  sticky flag: a config was accepted for cfg_chan >= NUM_CH.
- leds  output  NUM_CH  blink outputs, registered.

Behaviour:
- Reset (rstbtn_n=0 at an edge):
  - leds=0, cfg_err=0, cfg_ready=1.
  - All counters, pulse timers and pending flags = 0.
  - All intervals = 0 (channels disabled), rand = 0.
  - LFSR = LFSR_SEED.
  - Reset mid-pulse or mid-handshake aborts everything. Any pending update is discarded.
- Per-channel state:
  - active interval IVL and mode RND.
  - shadow interval/mode and a pending flag.
  - counter CNT (CNT_W bits).
  - pulse timer PT (4 bits).
- Counting, on an edge with en=1 and IVL!=0:
  - If CNT==IVL ("wrap"): CNT<=0 and PT<=PULSE_W. Otherwise CNT<=CNT+1.
  - Blink period is IVL+1 cycles. The first blink after enable/config follows IVL+1 cycles later.
  - leds[i] = (PT!=0). PT decrements each en cycle while nonzero.
  - A wrap while PT!=0 reloads PT, so the LED stays high continuously when PULSE_W > IVL.
- Disabled channel (IVL=0): CNT=0, PT=0, led=0.
- en=0:
  - Counters, pulse timers and LFSR are frozen.
  - leds forced 0, combinationally gated from the registered state.
  - When en returns, CNT/PT resume from their frozen values.
  - The config port keeps working while en=0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances once per en cycle.
  - At a wrap of a channel with RND=1: IVL <= LFSR[CNT_W-1:0]; a value of 0 is replaced by 1.
  - All random channels wrapping in the same cycle read the same LFSR value.
- Config handshake:
  - cfg_ready = !pending[cfg_chan] (combinational on cfg_chan). cfg_ready=1 for out-of-range cfg_chan.
  - Transfer occurs on an edge with cfg_valid && cfg_ready.
  - In-range transfer: shadow <= {cfg_interval, cfg_rand}, pending <= 1.
  - Out-of-range transfer: data dropped, cfg_err <= 1.
- Applying a pending update:
  - Applied at the channel's next wrap edge: IVL/RND <= shadow, CNT <= 0, pending <= 0.
  - That wrap still fires its pulse.
  - If shadow RND=1, the shadow interval is used for the first period only; subsequent wraps use the LFSR.
  - If the channel is disabled (IVL=0), the update applies on the edge after acceptance regardless of en.
- Simultaneous events:
  - A transfer on the same edge as a wrap does not apply at that wrap; it applies at the following wrap.
  - A pending update with cfg_interval=0 disables the channel at the next wrap (CNT=0, led drops after PT expires).

Optional Feature:
- Macro: BLINK_PHASE_SYNC_EN.
- Defined:
  - Adds input port sync_start (1 bit).
  - An edge with sync_start=1 forces all CNT<=0 and PT<=0, and applies all pending updates immediately. This is independent of en.
  - sync_start takes priority over wrap and over a same-edge config transfer; the transfer is still captured into the shadow and stays pending.
- Undefined: no sync_start port, no phase realignment logic.

Test Plan:
- Reset, write ch0 IVL=9 and ch1 IVL=4 with en=1 -> ch0 pulses every 10 cycles, ch1 every 5; led high exactly 1 cycle each; ch2 stays 0.
- ch1 running IVL=4; write IVL=2 mid-period -> cfg_ready for ch1 low until the next ch1 wrap; that pulse still occurs; then period 3.
- ch2 rand=1, IVL=3, en held 200 cycles -> interval sequence matches the LFSR model from seed ACE1; no zero interval; pulses on every wrap.
- Drop en for 7 cycles mid-count -> leds 0 during the gap; next pulse delayed by exactly 7 cycles.
- cfg_chan=3 with NUM_CH=3 -> cfg_ready=1, cfg_err sets and stays 1 until rstbtn_n=0; no channel changes.
- PULSE_W=3, IVL=1 -> led stays high continuously. Assert rstbtn_n=0 mid-pulse -> leds=0 next edge; pending cleared; cfg_ready=1.
